// File: rtl/pe_ctrl_pkg.sv
// Shared FSM state encoding and width helpers for the PE tile sequencer.
package pe_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Address width for n entries, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pe_delay_line.sv
// Fixed-depth enabled shift register: DEPTH enabled cycles from din to dout.
// Holds when en=0; sclr and aclr_n flush every stage to zero.
module pe_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             sclr,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_q [DEPTH];
   logic [WIDTH-1:0] pipe_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) pipe_d[i] = pipe_q[i];
      if (sclr) begin
         for (int i = 0; i < DEPTH; i++) pipe_d[i] = '0;
      end else if (en) begin
         pipe_d[0] = din;
         for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/pe_tile_sequencer.sv
// PE tile address sequencer: walks W/I/O_In addresses per block, O_Out delayed O_PipeLat cycles.
// Addresses are zero-latency from state; stall freezes everything and gates valids. PE_TILE_SEQ_PERF_EN adds stall_cycles.
module pe_tile_sequencer
   import pe_ctrl_pkg::*;
#(
   parameter int W_PEGroupSize   = 4,
   parameter int O_PEGroupSize   = 4,
   parameter int I_PEGroupSize   = W_PEGroupSize + O_PEGroupSize - 1,
   parameter int W_PEAddrWidth   = clog2_min1(W_PEGroupSize),
   parameter int I_PEAddrWidth   = clog2_min1(I_PEGroupSize),
   parameter int O_PEAddrWidth   = clog2_min1(O_PEGroupSize),
   parameter int BlockCountWidth = 4,
   parameter int O_PipeLat       = 2
) (
   input  logic                       clk,
   input  logic                       aclr_n,
   input  logic                       sclr,
   input  logic                       start,
   input  logic [BlockCountWidth-1:0] block_count,
   input  logic                       stall,
   output logic                       busy,
   output logic                       done,
   output logic [W_PEAddrWidth-1:0]   W_PEAddr,
   output logic                       W_Valid,
   output logic [I_PEAddrWidth-1:0]   I_PEAddr,
   output logic                       I_Valid,
   output logic [O_PEAddrWidth-1:0]   O_In_PEAddr,
   output logic                       O_In_Valid,
   output logic [O_PEAddrWidth-1:0]   O_Out_PEAddr,
   output logic                       O_Out_Valid,
   output logic [BlockCountWidth-1:0] I_Block_Counter,
   output logic [BlockCountWidth-1:0] O_Out_Block_Counter,
   output logic                       I_BLOCK_FIRST,
   output logic                       I_BLOCK_LAST,
   output logic                       O_OUT_BLOCK_LAST
`ifdef PE_TILE_SEQ_PERF_EN
   ,
   output logic [15:0]                stall_cycles
`endif
);

   localparam int DL_W  = 1 + O_PEAddrWidth + BlockCountWidth;
   localparam int DRN_W = clog2_min1(O_PipeLat);
   localparam logic [I_PEAddrWidth-1:0]   BEAT_LAST   = I_PEAddrWidth'(I_PEGroupSize - 1);
   localparam logic [I_PEAddrWidth-1:0]   W_BEAT_LAST = I_PEAddrWidth'(W_PEGroupSize - 1);
   localparam logic [I_PEAddrWidth-1:0]   BEAT_ONE    = I_PEAddrWidth'(1);
   localparam logic [BlockCountWidth-1:0] BLK_ONE     = BlockCountWidth'(1);
   localparam logic [DRN_W-1:0]           DRN_LAST    = DRN_W'(O_PipeLat - 1);
   localparam logic [DRN_W-1:0]           DRN_ONE     = DRN_W'(1);

   state_t                     state_q, state_d;
   logic [I_PEAddrWidth-1:0]   beat_q, beat_d;
   logic [BlockCountWidth-1:0] blk_q, blk_d;
   logic [BlockCountWidth-1:0] count_q, count_d;
   logic [DRN_W-1:0]           drain_q, drain_d;

   logic            run;
   logic            start_ok;
   logic            w_phase;
   logic            o_phase;
   logic            o_out_vld_raw;
   logic [DL_W-1:0] dl_in;
   logic [DL_W-1:0] dl_out;

   assign run      = (state_q == ST_RUN);
   assign start_ok = (state_q == ST_IDLE) && start && !stall;
   assign w_phase  = (beat_q <= W_BEAT_LAST);
   assign o_phase  = (beat_q >= W_BEAT_LAST);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      blk_d   = blk_q;
      count_d = count_q;
      drain_d = drain_q;
      if (sclr) begin
         state_d = ST_IDLE;
         beat_d  = '0;
         blk_d   = '0;
         count_d = '0;
         drain_d = '0;
      end else if (!stall) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  count_d = block_count;
                  beat_d  = '0;
                  blk_d   = '0;
                  state_d = (block_count == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (beat_q == BEAT_LAST) begin
                  beat_d = '0;
                  if (blk_q == count_q - BLK_ONE) begin
                     blk_d   = '0;
                     drain_d = '0;
                     state_d = ST_DRAIN;
                  end else begin
                     blk_d = blk_q + BLK_ONE;
                  end
               end else begin
                  beat_d = beat_q + BEAT_ONE;
               end
            end
            ST_DRAIN: begin
               if (drain_q == DRN_LAST) begin
                  drain_d = '0;
                  state_d = ST_DONE;
               end else begin
                  drain_d = drain_q + DRN_ONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         blk_q   <= '0;
         count_q <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         blk_q   <= blk_d;
         count_q <= count_d;
         drain_q <= drain_d;
      end
   end

   // beat_q is zero outside RUN, so the addresses need no state gating.
   assign I_PEAddr    = beat_q;
   assign W_PEAddr    = w_phase ? W_PEAddrWidth'(beat_q) : '0;
   assign O_In_PEAddr = o_phase ? O_PEAddrWidth'(beat_q - W_BEAT_LAST) : '0;
   assign I_Valid     = run && !stall;
   assign W_Valid     = run && !stall && w_phase;
   assign O_In_Valid  = run && !stall && o_phase;

   assign I_Block_Counter = blk_q;
   assign I_BLOCK_FIRST   = run && (blk_q == '0);
   assign I_BLOCK_LAST    = run && (blk_q == count_q - BLK_ONE);

   assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done = (state_q == ST_DONE);

   assign dl_in = {run && o_phase, O_In_PEAddr, blk_q};

   pe_delay_line #(
      .WIDTH (DL_W),
      .DEPTH (O_PipeLat)
   ) u_o_out_dly (
      .clk    (clk),
      .aclr_n (aclr_n),
      .sclr   (sclr),
      .en     (!stall),
      .din    (dl_in),
      .dout   (dl_out)
   );

   assign {o_out_vld_raw, O_Out_PEAddr, O_Out_Block_Counter} = dl_out;
   assign O_Out_Valid      = o_out_vld_raw && !stall;
   assign O_OUT_BLOCK_LAST = busy && (O_Out_Block_Counter == count_q - BLK_ONE);

`ifdef PE_TILE_SEQ_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (sclr || start_ok) begin
         stall_cnt_d = '0;
      end else if (stall && busy && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule
